// File: rtl/dac_spi_pkg.sv
// Shared types and helpers for the DAC SPI register controller.
// Build option: DAC_SPI_INIT_VERIFY_EN adds read-back of every init write.
package dac_spi_pkg;

  typedef enum logic [2:0] {
    RST_PULSE = 3'd0,
    INIT      = 3'd1,
    IDLE      = 3'd2,
    XFER      = 3'd3,
    DONE      = 3'd4,
    VERIFY    = 3'd5
  } state_t;

  localparam int FRAME_BITS      = 16;
  localparam int INIT_ENTRY_BITS = 24;

  // {rw, zero-padded 7-bit address, data}
  function automatic logic [FRAME_BITS-1:0] pack_frame(
    input logic       rw,
    input logic [6:0] addr,
    input logic [7:0] data
  );
    return {rw, addr, data};
  endfunction

endpackage

// File: rtl/dac_spi_ctrl_if.sv
// Host command bus between the system and the DAC SPI controller.
// Build option: DAC_SPI_INIT_VERIFY_EN (no effect on this bus).
interface dac_spi_ctrl_if;

  logic        cmd_trig_in;
  logic [15:0] cmd_addr_in;
  logic [15:0] cmd_data_in;
  logic [15:0] cmd_data_out;
  logic        busy_out;
  logic        done_out;
  logic        drop_out;

  modport master (
    output cmd_trig_in, cmd_addr_in, cmd_data_in,
    input  cmd_data_out, busy_out, done_out, drop_out
  );

  modport slave (
    input  cmd_trig_in, cmd_addr_in, cmd_data_in,
    output cmd_data_out, busy_out, done_out, drop_out
  );

endinterface

// File: rtl/dac_spi_ctrl_shifter.sv
// 16-bit SPI frame engine: SDO moves on SCK fall, SDI sampled on SCK rise.
// Build option: DAC_SPI_INIT_VERIFY_EN (no effect on this module).
module spi_frame_shifter
  import dac_spi_pkg::*;
#(
  parameter int N_DEV       = 2,
  parameter int SPI_CLK_DIV = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [N_DEV-1:0]      cs_sel,
  input  logic [FRAME_BITS-1:0] tx,
  output logic                  ready,
  output logic                  fin,
  output logic [FRAME_BITS-1:0] rx,
  output logic [N_DEV-1:0]      scs,
  output logic                  sck,
  output logic                  sdo,
  input  logic                  sdi
);

  localparam int DW = $clog2(SPI_CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SPI_CLK_DIV - 1);

  logic                  active;
  logic [DW-1:0]         div_cnt;
  logic [5:0]            hp;
  logic [FRAME_BITS-1:0] sh;

  assign ready = ~active;
  assign sdo   = sh[FRAME_BITS-1];

  // 34 half-periods: lead-in, 32 SCK phases, lead-out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      div_cnt <= '0;
      hp      <= '0;
      sh      <= '0;
      rx      <= '0;
      scs     <= '1;
      sck     <= 1'b0;
      fin     <= 1'b0;
    end else begin
      fin <= 1'b0;
      if (!active) begin
        if (start) begin
          active  <= 1'b1;
          scs     <= ~cs_sel;
          sh      <= tx;
          div_cnt <= '0;
          hp      <= '0;
        end
      end else if (div_cnt != DIV_LAST) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
        hp      <= hp + 6'd1;
        if (hp == 6'd33) begin
          active <= 1'b0;
          scs    <= '1;
          fin    <= 1'b1;
        end else if (hp == 6'd32) begin
          sck <= 1'b0;
        end else if (!hp[0]) begin
          sck <= 1'b1;
          rx  <= {rx[FRAME_BITS-2:0], sdi};
        end else begin
          sck <= 1'b0;
          sh  <= {sh[FRAME_BITS-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/dac_spi_ctrl.sv
// DAC reset pulse, init-table replay and host get/set over shared SPI.
// Build option: DAC_SPI_INIT_VERIFY_EN adds read-back of every init write.
module dac_spi_ctrl
  import dac_spi_pkg::*;
#(
  parameter int N_DEV       = 2,
  parameter int ADDR_BITS   = 5,
  parameter int SPI_CLK_DIV = 5,
  parameter int RST_CYCLES  = 255,
  parameter int INIT_DEPTH  = 1,
  parameter logic [INIT_ENTRY_BITS*((INIT_DEPTH > 0) ? INIT_DEPTH : 1)-1:0]
    INIT_TABLE = 24'h000500,
  parameter logic [7:0] GET_PREFIX = 8'h20,
  parameter logic [7:0] SET_PREFIX = 8'h21
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  dac_spi_ctrl_if.slave    bus,
  output logic             init_err_out,
  output logic             rst_out,
  output logic [N_DEV-1:0] spi_scs_out,
  output logic             spi_sck_out,
  output logic             spi_sdo_out,
  input  logic             spi_sdi_in
);

  localparam int CW = $clog2(RST_CYCLES + 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [4:0] DEPTH = 5'(INIT_DEPTH);
  localparam logic [7:0] NDEV8 = 8'(N_DEV);
  localparam logic [3:0] NDEV4 = 4'(N_DEV);
  localparam logic [7:0] AMASK = 8'((1 << ADDR_BITS) - 1);

  function automatic logic [6:0] pad_addr(input logic [7:0] a);
    return 7'(a & AMASK);
  endfunction

  state_t                state;
  logic [CW-1:0]         rst_cnt;
  logic [4:0]            idx;
  logic [FRAME_BITS-1:0] tx;
  logic [FRAME_BITS-1:0] rx;
  logic [N_DEV-1:0]      cs_sel;
  logic                  start;
  logic                  ready;
  logic                  fin;
  logic                  is_init;
  logic                  is_read;
  logic                  done;
  logic                  drop;
  logic [7:0]            rdata;
  logic [8:0]            off;
  logic [23:0]           entry;
  logic [7:0]            prefix;
  logic [2:0]            dev;
  logic                  is_get;
  logic                  cmd_ok;
  logic                  unused_bits;

  assign off    = {idx, 4'b0} + {1'b0, idx, 3'b0};
  assign entry  = 24'(INIT_TABLE >> off);
  assign prefix = bus.cmd_addr_in[15:8];
  assign dev    = bus.cmd_addr_in[7:5];
  assign is_get = (prefix == GET_PREFIX);
  assign cmd_ok = (is_get || prefix == SET_PREFIX)
               && ({1'b0, dev} < NDEV4);

  assign bus.busy_out     = (state != IDLE);
  assign bus.done_out     = done;
  assign bus.drop_out     = drop;
  assign bus.cmd_data_out = {8'h00, rdata};
  assign unused_bits      = ^{bus.cmd_data_in[15:8], rx[15:8]};

`ifdef DAC_SPI_INIT_VERIFY_EN
  logic       vfy;
  logic       err;
  logic [7:0] wr_data;
  assign init_err_out = err;
`else
  assign init_err_out = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state   <= RST_PULSE;
      rst_cnt <= '0;
      rst_out <= 1'b1;
      idx     <= '0;
      tx      <= '0;
      cs_sel  <= '0;
      start   <= 1'b0;
      is_init <= 1'b0;
      is_read <= 1'b0;
      done    <= 1'b0;
      drop    <= 1'b0;
      rdata   <= '0;
`ifdef DAC_SPI_INIT_VERIFY_EN
      vfy     <= 1'b0;
      err     <= 1'b0;
      wr_data <= '0;
`endif
    end else begin
      start <= 1'b0;
      done  <= 1'b0;
      drop  <= 1'b0;
      if (bus.cmd_trig_in && state != IDLE) drop <= 1'b1;
      case (state)
        RST_PULSE: begin
          if (rst_cnt == RST_LAST) begin
            rst_out <= 1'b0;
            state   <= INIT;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        INIT: begin
          if (idx == DEPTH) begin
            state <= IDLE;
          end else if (entry[23:16] >= NDEV8) begin
            idx <= idx + 5'd1;
          end else if (ready) begin
            tx      <= pack_frame(1'b0, pad_addr(entry[15:8]), entry[7:0]);
            cs_sel  <= N_DEV'(1) << entry[23:16];
            is_init <= 1'b1;
            start   <= 1'b1;
            state   <= XFER;
`ifdef DAC_SPI_INIT_VERIFY_EN
            vfy     <= 1'b0;
            wr_data <= entry[7:0];
`endif
          end
        end
        IDLE: begin
          if (bus.cmd_trig_in) begin
            if (!cmd_ok) begin
              drop <= 1'b1;
            end else begin
              tx <= pack_frame(is_get, pad_addr(bus.cmd_addr_in[7:0]),
                               is_get ? 8'h00 : bus.cmd_data_in[7:0]);
              cs_sel  <= N_DEV'(1) << dev;
              is_read <= is_get;
              is_init <= 1'b0;
              start   <= 1'b1;
              state   <= XFER;
            end
          end
        end
        XFER: begin
          if (fin) begin
            if (is_init) begin
`ifdef DAC_SPI_INIT_VERIFY_EN
              if (!vfy) begin
                state <= VERIFY;
              end else begin
                if (rx[7:0] != wr_data) err <= 1'b1;
                idx   <= idx + 5'd1;
                state <= INIT;
              end
`else
              idx   <= idx + 5'd1;
              state <= INIT;
`endif
            end else begin
              done  <= 1'b1;
              state <= DONE;
              if (is_read) rdata <= rx[7:0];
            end
          end
        end
        DONE: state <= IDLE;
`ifdef DAC_SPI_INIT_VERIFY_EN
        VERIFY: begin
          if (ready) begin
            tx    <= pack_frame(1'b1, tx[14:8], 8'h00);
            vfy   <= 1'b1;
            start <= 1'b1;
            state <= XFER;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  spi_frame_shifter #(
    .N_DEV       (N_DEV),
    .SPI_CLK_DIV (SPI_CLK_DIV)
  ) u_shift (
    .clk    (clk_in),
    .rst_n  (rst_n_in),
    .start  (start),
    .cs_sel (cs_sel),
    .tx     (tx),
    .ready  (ready),
    .fin    (fin),
    .rx     (rx),
    .scs    (spi_scs_out),
    .sck    (spi_sck_out),
    .sdo    (spi_sdo_out),
    .sdi    (spi_sdi_in)
  );

endmodule

// File: tb/tb_dac_spi_ctrl.sv
// Directed bench for dac_spi_ctrl with an SPI slave model on the pins.
// Build option: DAC_SPI_INIT_VERIFY_EN changes the init expectations.
module tb_dac_spi_ctrl;

  localparam int DIV = 2;
  localparam int FRAME_LEN = 34 * DIV;

`ifdef DAC_SPI_INIT_VERIFY_EN
  localparam int          INIT_FRAMES = 2;
  localparam logic [15:0] LAST_INIT   = 16'h8500;
  localparam logic        EXP_ERR     = 1'b1;
`else
  localparam int          INIT_FRAMES = 1;
  localparam logic [15:0] LAST_INIT   = 16'h053C;
  localparam logic        EXP_ERR     = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sdi = 1'b0;
  logic       init_err;
  logic       rst_o;
  logic [1:0] scs;
  logic       sck;
  logic       sdo;

  dac_spi_ctrl_if bus ();

  dac_spi_ctrl #(
    .N_DEV       (2),
    .ADDR_BITS   (5),
    .SPI_CLK_DIV (DIV),
    .RST_CYCLES  (4),
    .INIT_DEPTH  (1),
    .INIT_TABLE  (24'h00053C),
    .GET_PREFIX  (8'h20),
    .SET_PREFIX  (8'h21)
  ) dut (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .bus          (bus),
    .init_err_out (init_err),
    .rst_out      (rst_o),
    .spi_scs_out  (scs),
    .spi_sck_out  (sck),
    .spi_sdo_out  (sdo),
    .spi_sdi_in   (sdi)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n++;

  // slave model: captures SDO on SCK rise, shifts resp out on SCK fall
  logic        cs_act;
  logic [15:0] resp = 16'h0000;
  logic [15:0] cap = 16'h0000;
  logic [15:0] last_frame = 16'h0000;
  logic [1:0]  cur_scs = 2'b11;
  logic [1:0]  last_scs = 2'b11;
  int          nbits = 0;
  int          kfall = 0;
  int          frames = 0;
  int          cs_starts = 0;
  int          t0 = 0;
  int          last_len = 0;

  assign cs_act = ~&scs;

  initial begin
    forever begin
      @(posedge cs_act);
      cs_starts++;
      t0 = cyc_n;
      nbits = 0;
      kfall = 0;
      cap = 16'h0000;
      cur_scs = scs;
      sdi = resp[15];
      while (cs_act) begin
        @(sck or cs_act);
        if (cs_act && sck) begin
          cap = {cap[14:0], sdo};
          nbits++;
        end else if (cs_act && !sck) begin
          kfall++;
          if (kfall < 16) sdi = resp[15-kfall];
        end
      end
      if (nbits == 16) begin
        frames++;
        last_frame = cap;
        last_scs = cur_scs;
        last_len = cyc_n - t0;
      end
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic pulse(input logic [15:0] a, input logic [15:0] d);
    bus.cmd_trig_in = 1'b1;
    bus.cmd_addr_in = a;
    bus.cmd_data_in = d;
    @(negedge clk);
    bus.cmd_trig_in = 1'b0;
  endtask

  task automatic release_reset();
    int n;
    rst_n = 1'b1;
    n = 0;
    while (rst_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("rst_pulse_len", n, 4);
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 1000; i++) begin
      if (!bus.busy_out) break;
      @(negedge clk);
    end
    chk(nm, bus.busy_out, 0);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic [7:0]  sdi_byte;
    logic        drop;
    logic [15:0] frame;
    logic [1:0]  scs;
    logic [15:0] rdata;
  } vec_t;

  vec_t vt[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int fb;
    int cb;
    bus.cmd_trig_in = 1'b0;
    bus.cmd_addr_in = 16'h0000;
    bus.cmd_data_in = 16'h0000;

    vt[0] = '{16'h2003, 16'h0000, 8'h5A, 1'b0, 16'h8300, 2'b10, 16'h005A};
    vt[1] = '{16'h2102, 16'h00A5, 8'h00, 1'b0, 16'h02A5, 2'b10, 16'h005A};
    vt[2] = '{16'h2201, 16'h0011, 8'h00, 1'b1, 16'h0000, 2'b11, 16'h005A};
    vt[3] = '{16'h20E1, 16'h0000, 8'h00, 1'b1, 16'h0000, 2'b11, 16'h005A};
    vt[4] = '{16'h203F, 16'h0000, 8'hC3, 1'b0, 16'h9F00, 2'b01, 16'h00C3};
    vt[5] = '{16'h211F, 16'h1234, 8'h00, 1'b0, 16'h1F34, 2'b10, 16'h00C3};
    vt[6] = '{16'h215F, 16'h0042, 8'h00, 1'b1, 16'h0000, 2'b11, 16'h00C3};
    vt[7] = '{16'h2125, 16'h0077, 8'h99, 1'b0, 16'h0577, 2'b01, 16'h00C3};

    repeat (3) @(negedge clk);
    chk("reset_rst_out", rst_o, 1);
    chk("reset_scs", scs, 2'b11);
    chk("reset_sck", sck, 0);
    chk("reset_sdo", sdo, 0);
    chk("reset_busy", bus.busy_out, 1);
    chk("reset_done", bus.done_out, 0);
    chk("reset_drop", bus.drop_out, 0);
    chk("reset_err", init_err, 0);
    chk("reset_rdata", bus.cmd_data_out, 16'h0000);

    release_reset();
    repeat (3) @(negedge clk);
    pulse(16'h2102, 16'h00A5);
    chk("drop_in_init", bus.drop_out, 1);
    @(negedge clk);
    chk("drop_one_cycle", bus.drop_out, 0);
    wait_idle("init_idle");
    chk("init_frames", frames, INIT_FRAMES);
    chk("init_cs_starts", cs_starts, INIT_FRAMES);
    chk("init_frame", last_frame, LAST_INIT);
    chk("init_scs", last_scs, 2'b10);
    chk("init_len", last_len, FRAME_LEN);
    chk("init_rst_low", rst_o, 0);
    chk("init_err", init_err, EXP_ERR);

    foreach (vt[i]) begin
      resp = {8'hFF, vt[i].sdi_byte};
      fb = frames;
      cb = cs_starts;
      pulse(vt[i].addr, vt[i].data);
      chk($sformatf("v%0d_drop", i), bus.drop_out, vt[i].drop);
      if (vt[i].drop) begin
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d_no_cs", i), cs_starts, cb);
        chk($sformatf("v%0d_idle", i), bus.busy_out, 0);
      end else begin
        chk($sformatf("v%0d_busy", i), bus.busy_out, 1);
        for (int k = 0; k < 400; k++) begin
          if (bus.done_out) break;
          @(negedge clk);
        end
        chk($sformatf("v%0d_done", i), bus.done_out, 1);
        chk($sformatf("v%0d_rdata", i), bus.cmd_data_out, vt[i].rdata);
        chk($sformatf("v%0d_busy_done", i), bus.busy_out, 1);
        @(negedge clk);
        chk($sformatf("v%0d_done_once", i), bus.done_out, 0);
        chk($sformatf("v%0d_idle", i), bus.busy_out, 0);
        chk($sformatf("v%0d_nframes", i), frames, fb + 1);
        chk($sformatf("v%0d_frame", i), last_frame, vt[i].frame);
        chk($sformatf("v%0d_scs", i), last_scs, vt[i].scs);
        chk($sformatf("v%0d_len", i), last_len, FRAME_LEN);
      end
    end

    // trigger landing on the DONE cycle
    pulse(16'h2102, 16'h0033);
    for (int k = 0; k < 400; k++) begin
      if (bus.done_out) break;
      @(negedge clk);
    end
    chk("done_cycle_seen", bus.done_out, 1);
    cb = cs_starts;
    pulse(16'h2102, 16'h0044);
    chk("done_cycle_drop", bus.drop_out, 1);
    chk("done_cycle_idle", bus.busy_out, 0);
    repeat (5) @(negedge clk);
    chk("done_cycle_no_cs", cs_starts, cb);
    chk("err_sticky", init_err, EXP_ERR);

    // reset in the middle of a frame
    resp = 16'h0000;
    cb = cs_starts;
    pulse(16'h2102, 16'h00A5);
    for (int k = 0; k < 400; k++) begin
      if (cs_starts != cb && nbits >= 8) break;
      @(negedge clk);
    end
    chk("abort_reached_bit8", nbits, 8);
    fb = frames;
    #1 rst_n = 1'b0;
    #1;
    chk("abort_scs", scs, 2'b11);
    chk("abort_sck", sck, 0);
    chk("abort_rst_out", rst_o, 1);
    chk("abort_busy", bus.busy_out, 1);
    @(negedge clk);
    chk("abort_no_frame", frames, fb);
    cb = cs_starts;
    release_reset();
    wait_idle("restart_idle");
    chk("restart_frames", frames, fb + INIT_FRAMES);
    chk("restart_cs_starts", cs_starts, cb + INIT_FRAMES);
    chk("restart_frame", last_frame, LAST_INIT);
    chk("restart_err", init_err, EXP_ERR);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
